qc_ldpc_encoder: RTL and testbench

QC_LDPC_ENCODER -- requirements
Module: qc_ldpc_encoder

---
 rtl/qc_ldpc_encoder.sv | 152 +++++++++++++++
 tb/tb_qc_ldpc_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qc_ldpc_encoder.sv
// Quasi-cyclic LDPC parity encoder: streams a K-bit message, accumulates
// circulant-rotated base rows into a PW-bit parity register, then streams out the parity.
module qc_ldpc_encoder #(
  parameter int DW    = 8,
  parameter int CW    = 256,
  parameter int NCELL = 4,
  parameter int KB    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [((KB > 1) ? $clog2(KB) : 1)-1:0] g_addr,
  input  logic [NCELL*CW-1:0]           g_data,
  output logic [DW-1:0]                 m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          busy
);

  localparam int PW    = NCELL * CW;
  localparam int BPR   = CW / DW;
  localparam int NWORD = PW / DW;
  localparam int AW    = (KB > 1) ? $clog2(KB) : 1;
  localparam int TW    = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int NW    = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam int SW    = (CW > 1) ? $clog2(CW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [PW-1:0]   b_q, b_d;
  logic [AW-1:0]   r_q, r_d;
  logic [TW-1:0]   t_q, t_d;
  logic [NW-1:0]   n_q, n_d;
  logic [PW-1:0]   upd;
  logic            s_fire, m_fire;
  logic            last_beat, last_row, last_word;

  // Rotate left within one circulant: bit i moves to bit (i+s) mod CW.
  function automatic logic [CW-1:0] rotl(input logic [CW-1:0] x, input logic [SW-1:0] s);
    logic [2*CW-1:0] dbl;
    dbl = {x, x} << s;
    return dbl[2*CW-1:CW];
  endfunction

  assign s_fire    = s_valid & s_ready;
  assign m_fire    = m_valid & m_ready;
  assign last_beat = (t_q == TW'(BPR - 1));
  assign last_row  = (r_q == AW'(KB - 1));
  assign last_word = (n_q == NW'(NWORD - 1));

  // Contribution of one beat: every set message bit adds its rotated base row.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    upd = '0;
    for (int c = 0; c < NCELL; c++) begin
      for (int b = 0; b < DW; b++) begin
        if (s_data[b]) begin
          upd[c*CW +: CW] = upd[c*CW +: CW] ^ rotl(b_q[c*CW +: CW], SW'(int'(t_q) * DW + b));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (s_valid) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_RUN;
      S_RUN:   if (s_fire && last_beat) state_d = last_row ? S_DRAIN : S_FETCH;
      S_DRAIN: if (m_fire && last_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == S_RUN);
    m_valid = (state_q == S_DRAIN);
    m_last  = (state_q == S_DRAIN) && last_word;
    busy    = (state_q != S_IDLE);
    g_addr  = r_q;
    m_data  = (state_q == S_DRAIN) ? p_q[DW-1:0] : '0;
  end

  always_comb begin
    p_d = p_q;
    b_d = b_q;
    r_d = r_q;
    t_d = t_q;
    n_d = n_q;
    case (state_q)
      S_WAIT: b_d = g_data;
      S_RUN: begin
        if (s_fire) begin
          p_d = p_q ^ upd;
          t_d = last_beat ? '0 : t_q + TW'(1);
          if (last_beat && !last_row) r_d = r_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (m_fire) begin
          if (last_word) begin
            p_d = '0;
            r_d = '0;
            n_d = '0;
          end else begin
            // Rotate right so the next output word always sits in the low bits.
            p_d = {p_q[DW-1:0], p_q[PW-1:DW]};
            n_d = n_q + NW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      b_q <= '0;
      r_q <= '0;
      t_q <= '0;
      n_q <= '0;
    end else begin
      p_q <= p_d;
      b_q <= b_d;
      r_q <= r_d;
      t_q <= t_d;
      n_q <= n_d;
    end
  end

endmodule

// File: tb/tb_qc_ldpc_encoder.sv
// Bench for qc_ldpc_encoder (DW=8, CW=16, NCELL=2, KB=2): vector table plus
// reference model, scoreboard of expected parity words, and reset/stall corner cases.
module tb_qc_ldpc_encoder;

  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int NCELL = 2;
  localparam int KB    = 2;
  localparam int PW    = NCELL * CW;
  localparam int NBEAT = KB * CW / DW;
  localparam int NWORD = PW / DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [0:0]    g_addr;
  logic [PW-1:0] g_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;

  qc_ldpc_encoder #(.DW(DW), .CW(CW), .NCELL(NCELL), .KB(KB)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .g_addr  (g_addr),
    .g_data  (g_data),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] rom [KB];
  initial begin
    rom[0] = 32'h0003_0001;
    rom[1] = 32'h8000_0100;
  end
  always @(posedge clk) g_data <= rom[g_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    logic [PW-1:0] msg;
    logic [PW-1:0] par;
    bit            toggle;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   xfer_cyc [NBEAT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: message bit k lands in row k/CW at rotation k%CW.
  function automatic logic [PW-1:0] model(input logic [PW-1:0] msg);
    logic [PW-1:0] p = '0;
    logic [PW-1:0] row;
    for (int k = 0; k < KB * CW; k++) begin
      if (msg[k]) begin
        row = rom[k / CW];
        for (int c = 0; c < NCELL; c++)
          for (int i = 0; i < CW; i++)
            if (row[c*CW + i]) p[c*CW + (i + k % CW) % CW] = ~p[c*CW + (i + k % CW) % CW];
      end
    end
    return p;
  endfunction

  // Output monitor: pops the scoreboard on every accepted word, checks hold under stall.
  logic          stalled = 1'b0;
  logic [DW-1:0] held = '0;
  exp_t          mon_e;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && m_valid) check("held_data", m_data, held);
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", m_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check("word", m_data, mon_e.data);
          check("last", m_last, mon_e.last);
        end
      end
    end
  end

  task automatic push_expected(input logic [PW-1:0] par);
    for (int n = 0; n < NWORD; n++)
      sb.push_back('{data: par[n*DW +: DW], last: (n == NWORD - 1)});
  endtask

  task automatic send_msg(input logic [PW-1:0] msg, input int nbeats, input bit bubbles);
    bit got;
    int budget;
    for (int i = 0; i < nbeats; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = msg[i*DW +: DW];
      got     = 1'b0;
      budget  = 0;
      while (!got && budget < 50) begin
        @(negedge clk);
        got = s_ready;
        if (got) xfer_cyc[i] = cyc;
        @(posedge clk); #1;
        budget++;
      end
      if (!got) check("xfer_timeout", got, 1);
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic drain(input bit toggle, input bit hold_svalid, output int used);
    used = 0;
    for (int k = 0; k < 200; k++) begin
      m_ready = toggle ? k[0] : 1'b1;
      if (hold_svalid) s_valid = 1'b1;
      @(negedge clk);
      if (hold_svalid && m_valid) check("s_ready_in_drain", s_ready, 0);
      @(posedge clk); #1;
      used++;
      if (sb.size() == 0) break;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("drain_complete", sb.size(), 0);
    sb.delete();
    check("idle_after_last_busy", busy, 0);
    check("idle_after_last_valid", m_valid, 0);
  endtask

  task automatic run_vec(input logic [PW-1:0] msg, input logic [PW-1:0] par,
                         input bit toggle, input bit bubbles);
    int used;
    push_expected(par);
    send_msg(msg, NBEAT, bubbles);
    check("first_valid", m_valid, 1);
    drain(toggle, 1'b0, used);
  endtask

  vec_t vecs [6];
  int   used;
  logic [PW-1:0] rmsg;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{msg: 32'h0000_0000, par: 32'h0000_0000, toggle: 1'b0};
    vecs[1] = '{msg: 32'h0000_0001, par: 32'h0003_0001, toggle: 1'b0};
    vecs[2] = '{msg: 32'h0000_0002, par: 32'h0006_0002, toggle: 1'b0};
    vecs[3] = '{msg: 32'h0001_0000, par: 32'h8000_0100, toggle: 1'b0};
    vecs[4] = '{msg: 32'h0000_0003, par: 32'h0005_0003, toggle: 1'b1};
    vecs[5] = '{msg: 32'h8000_0000, par: 32'h4000_0080, toggle: 1'b1};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    check("rst_g_addr", g_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i].msg, vecs[i].par, vecs[i].toggle, 1'b0);

    // Continuous s_valid: two stall cycles between rows, parity right after last beat.
    rmsg = 32'h1234_5678;
    push_expected(model(rmsg));
    send_msg(rmsg, NBEAT, 1'b0);
    check("first_valid_cont", m_valid, 1);
    check("gap_beat1", xfer_cyc[1] - xfer_cyc[0], 1);
    check("gap_row_stall", xfer_cyc[2] - xfer_cyc[1], 3);
    check("gap_beat3", xfer_cyc[3] - xfer_cyc[2], 1);
    drain(1'b0, 1'b1, used);
    check("drain_cycles", used, NWORD);

    // Reset mid-RUN discards the partial codeword.
    send_msg(32'hFFFF_FFFF, 3, 1'b0);
    check("busy_mid_run", busy, 1);
    check("g_addr_row1", g_addr, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_g_addr", g_addr, 0);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("no_stale_valid", m_valid, 0);
    end
    run_vec(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

    // Reset mid-DRAIN drops the pending parity.
    m_ready = 1'b0;
    send_msg(32'hA5A5_A5A5, NBEAT, 1'b0);
    check("drain_stalled_valid", m_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    check("middrain_rst_valid", m_valid, 0);
    check("middrain_rst_data", m_data, 0);
    run_vec(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

    // Random messages with input bubbles and output back-pressure.
    for (int i = 0; i < 4; i++) begin
      rmsg = $urandom();
      run_vec(rmsg, model(rmsg), 1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
